// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio mixer/scheduler.
//   SAMPLE_W   - width of one audio sample (16-bit signed)
//   acc_width  - accumulator width for a given channel count
//   state_t    - mixer FSM states
//   sat16      - clamp a sign-extended 32-bit value to 16 bits, with clip flag
package audio_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int CHANNELS_DEF = 4;

  // One guard bit above clog2 growth, so the sum of CHANNELS samples never wraps.
  function automatic int acc_width(input int ch);
    return SAMPLE_W + $clog2(ch) + 1;
  endfunction

  localparam int ACC_W = acc_width(CHANNELS_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } state_t;

  // Returns {clip, value}: value clamped to [-32768, 32767].
  function automatic logic [16:0] sat16(input logic signed [31:0] v);
    logic [16:0] res;
    if (v > 32'sd32767) begin
      res = {1'b1, 16'h7FFF};
    end else if (v < -32'sd32768) begin
      res = {1'b1, 16'h8000};
    end else begin
      res = {1'b0, v[15:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_mixer_sched_if.sv
// audio_mixer_sched_if: sample-source handshake plus mixed output words.
//   src_valid/src_ready - per-channel poll handshake
//   src_l/src_r         - packed signed samples, channel i at [16i+15:16i]
//   ldata/rdata/frame   - mixed stereo pair and its update pulse
//   master: the mixer side; slave: the sources/serializer side.
interface audio_mixer_sched_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]    src_valid;
  logic [CHANNELS-1:0]    src_ready;
  logic [16*CHANNELS-1:0] src_l;
  logic [16*CHANNELS-1:0] src_r;
  logic [15:0]            ldata;
  logic [15:0]            rdata;
  logic                   frame;

  modport master (
    input  src_valid, src_l, src_r,
    output src_ready, ldata, rdata, frame
  );

  modport slave (
    output src_valid, src_l, src_r,
    input  src_ready, ldata, rdata, frame
  );
endinterface

// File: rtl/audio_sat.sv
// audio_sat: combinational clamp of a W-bit signed value to 16 bits.
//   din  - wide signed accumulator value (W <= 32)
//   dout - clamped 16-bit signed result
//   clip - high when din lay outside the 16-bit range
module audio_sat
  import audio_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic signed [W-1:0] din,
  output logic signed [15:0]  dout,
  output logic                clip
);
  logic signed [31:0] ext_s;
  logic [16:0]        res_s;

  assign ext_s = {{(32-W){din[W-1]}}, din};
  assign res_s = sat16(ext_s);
  assign dout  = res_s[15:0];
  assign clip  = res_s[16];
endmodule

// File: rtl/audio_mixer_sched.sv
// audio_mixer_sched: once per FRAME cycles, polls CHANNELS sources in order,
// sums them in a shared accumulator, saturates, and publishes ldata/rdata.
//   clock, reset (sync, active-low)
//   bus      - audio_mixer_sched_if.master (sources in, mixed words out)
//   gain     - per-channel arithmetic right shift, only with AUDIO_MIX_GAIN_EN
//   underrun - sticky per-channel "not valid when polled"
//   clip     - sticky "a saturation occurred"
// Optional feature macro: AUDIO_MIX_GAIN_EN.
module audio_mixer_sched
  import audio_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int FRAME    = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  audio_mixer_sched_if.master   bus,
`ifdef AUDIO_MIX_GAIN_EN
  input  logic [3*CHANNELS-1:0] gain,
`endif
  output logic [CHANNELS-1:0]   underrun,
  output logic                  clip
);
  localparam int AW    = acc_width(CHANNELS);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(FRAME);

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      count_r;
  logic [IDX_W-1:0]      idx_r;
  logic signed [AW-1:0]  acc_left_r, acc_right_r;
  logic [15:0]           ldata_r, rdata_r;
  logic                  frame_r;
  logic [CHANNELS-1:0]   underrun_r;
  logic                  clip_r;
  logic [CHANNELS-1:0]   ready_s;

  logic                  tick_s, last_s, valid_s;
  logic signed [15:0]    samp_l_s, samp_r_s, shl_l_s, shl_r_s;
  logic signed [AW-1:0]  ext_l_s, ext_r_s;
  logic signed [15:0]    sat_l_s, sat_r_s;
  logic                  clip_l_s, clip_r_s;

  assign tick_s   = (count_r == CNT_W'(FRAME - 1));
  assign last_s   = (idx_r == IDX_W'(CHANNELS - 1));
  assign valid_s  = bus.src_valid[idx_r];
  assign samp_l_s = bus.src_l[int'(idx_r)*SAMPLE_W +: SAMPLE_W];
  assign samp_r_s = bus.src_r[int'(idx_r)*SAMPLE_W +: SAMPLE_W];

`ifdef AUDIO_MIX_GAIN_EN
  // Attenuation floors toward -inf, so small negatives settle at -1.
  assign shl_l_s = samp_l_s >>> gain[int'(idx_r)*3 +: 3];
  assign shl_r_s = samp_r_s >>> gain[int'(idx_r)*3 +: 3];
`else
  assign shl_l_s = samp_l_s;
  assign shl_r_s = samp_r_s;
`endif

  assign ext_l_s = {{(AW-16){shl_l_s[15]}}, shl_l_s};
  assign ext_r_s = {{(AW-16){shl_r_s[15]}}, shl_r_s};

  audio_sat #(.W(AW)) u_sat_l (.din(acc_left_r),  .dout(sat_l_s), .clip(clip_l_s));
  audio_sat #(.W(AW)) u_sat_r (.din(acc_right_r), .dout(sat_r_s), .clip(clip_r_s));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and the same-cycle ready pulse for the polled channel.
  always_comb begin
    state_s = state_r;
    ready_s = '0;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_s = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (valid_s) begin
          ready_s[idx_r] = 1'b1;
        end else begin
          ready_s = '0;
        end
        if (last_s) begin
          state_s = SAT;
        end else begin
          state_s = ACC;
        end
      end
      SAT:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Frame counter, accumulators, sticky flags and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_r     <= '0;
      idx_r       <= '0;
      acc_left_r  <= '0;
      acc_right_r <= '0;
      ldata_r     <= 16'h0000;
      rdata_r     <= 16'h0000;
      frame_r     <= 1'b0;
      underrun_r  <= '0;
      clip_r      <= 1'b0;
    end else begin
      count_r <= tick_s ? '0 : count_r + CNT_W'(1);
      frame_r <= (state_r == SAT);
      case (state_r)
        IDLE: begin
          if (tick_s) begin
            idx_r       <= '0;
            acc_left_r  <= '0;
            acc_right_r <= '0;
          end
        end
        ACC: begin
          // Missing source contributes silence and is flagged.
          if (valid_s) begin
            acc_left_r  <= acc_left_r + ext_l_s;
            acc_right_r <= acc_right_r + ext_r_s;
          end else begin
            underrun_r[idx_r] <= 1'b1;
          end
          if (!last_s) begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        SAT: begin
          ldata_r <= sat_l_s;
          rdata_r <= sat_r_s;
          if (clip_l_s || clip_r_s) begin
            clip_r <= 1'b1;
          end
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign bus.src_ready = ready_s;
  assign bus.ldata     = ldata_r;
  assign bus.rdata     = rdata_r;
  assign bus.frame     = frame_r;
  assign underrun      = underrun_r;
  assign clip          = clip_r;
endmodule

// File: tb/tb_audio_mixer_sched.sv
module tb_audio_mixer_sched;
  localparam int CH = 4;
  localparam int FR = 32;

  logic clock;
  logic reset;
  logic [CH-1:0] underrun;
  logic clip;
`ifdef AUDIO_MIX_GAIN_EN
  logic [3*CH-1:0] gain;
`endif

  audio_mixer_sched_if #(.CHANNELS(CH)) bus ();

  audio_mixer_sched #(.CHANNELS(CH), .FRAME(FR)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.master),
`ifdef AUDIO_MIX_GAIN_EN
    .gain     (gain),
`endif
    .underrun (underrun),
    .clip     (clip)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int frames = 0;
  int unstable = 0;
  bit stable_en = 1'b0;
  logic [15:0] prev_l = 16'h0000;
  int rdy_cyc [CH];
  int rdy_cnt [CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: sample at the falling edge and record pulses.
  task automatic step();
    @(negedge clock);
    if (bus.src_ready != '0) begin
      check_eq("ready_onehot", 32'($onehot(bus.src_ready)), 32'd1);
      for (int i = 0; i < CH; i++) begin
        if (bus.src_ready[i]) begin
          rdy_cyc[i] = cyc;
          rdy_cnt[i]++;
        end
      end
    end
    if (stable_en && !bus.frame && bus.ldata != prev_l) unstable++;
    prev_l = bus.ldata;
    if (bus.frame) frames++;
  endtask

  task automatic clear_ready();
    for (int i = 0; i < CH; i++) begin
      rdy_cyc[i] = -1;
      rdy_cnt[i] = 0;
    end
  endtask

  task automatic wait_frame(output int fc);
    bit seen;
    seen = 1'b0;
    fc = -1;
    for (int n = 0; n < 4*FR && !seen; n++) begin
      step();
      if (bus.frame) begin
        seen = 1'b1;
        fc = cyc;
      end
    end
    if (!seen) check_eq("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ldata"}, bus.ldata, 16'h0000);
    check_eq({tag, "_rdata"}, bus.rdata, 16'h0000);
    check_eq({tag, "_frame"}, bus.frame, 1'b0);
    check_eq({tag, "_ready"}, bus.src_ready, 4'h0);
    check_eq({tag, "_underrun"}, underrun, 4'h0);
    check_eq({tag, "_clip"}, clip, 1'b0);
  endtask

  initial begin
    int fc, last_fc, rel_cyc, fr_before;
    bit got1;
    reset = 1'b0;
`ifdef AUDIO_MIX_GAIN_EN
    gain = '0;
`endif
    bus.src_valid = 4'b1111;
    bus.src_l = {16'h0000, 16'hFE0C, 16'h07D0, 16'h03E8};  // 0, -500, 2000, 1000
    bus.src_r = {16'd40, 16'd30, 16'd20, 16'd10};
    clear_ready();
    repeat (3) step();
    check_reset_state("rst");

    // Basic mix and poll timing.
    reset = 1'b1;
    rel_cyc = cyc;
    wait_frame(fc);
    check_eq("first_frame_delay", 32'(fc - rel_cyc), 32'(FR + CH + 1));
    check_eq("mix_l", bus.ldata, 16'd2500);
    check_eq("mix_r", bus.rdata, 16'd100);
    check_eq("mix_clip", clip, 1'b0);
    check_eq("mix_underrun", underrun, 4'h0);
    for (int i = 0; i < CH; i++) begin
      check_eq($sformatf("ready_time%0d", i), 32'(fc - rdy_cyc[i]), 32'(5 - i));
      check_eq($sformatf("ready_cnt%0d", i), 32'(rdy_cnt[i]), 32'd1);
    end
    last_fc = fc;

    // Positive and negative saturation.
    bus.src_l = {4{16'h7530}};  // 30000
    bus.src_r = {4{16'h8AD0}};  // -30000
    clear_ready();
    wait_frame(fc);
    check_eq("frame_spacing", 32'(fc - last_fc), 32'(FR));
    check_eq("sat_pos_l", bus.ldata, 16'h7FFF);
    check_eq("sat_neg_r", bus.rdata, 16'h8000);
    check_eq("sat_clip", clip, 1'b1);
    last_fc = fc;

    // Channel 2 missing.
    bus.src_valid = 4'b1011;
    bus.src_l = {16'd300, 16'd5000, 16'd200, 16'd100};
    bus.src_r = {16'd4, 16'd3, 16'd2, 16'd1};
    clear_ready();
    wait_frame(fc);
    check_eq("ur_l", bus.ldata, 16'd600);
    check_eq("ur_r", bus.rdata, 16'd7);
    check_eq("ur_flag", underrun, 4'b0100);
    check_eq("ur_no_ready2", 32'(rdy_cnt[2]), 32'd0);
    check_eq("ur_ready3", 32'(rdy_cnt[3]), 32'd1);
    check_eq("clip_sticky", clip, 1'b1);

    // Underrun stays set once source recovers.
    bus.src_valid = 4'b1111;
    bus.src_l = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.src_r = {4{16'h0000}};
    clear_ready();
    wait_frame(fc);
    check_eq("rec_l", bus.ldata, 16'd10);
    check_eq("rec_r", bus.rdata, 16'd0);
    check_eq("ur_sticky", underrun, 4'b0100);

`ifdef AUDIO_MIX_GAIN_EN
    gain = 12'h002;
    bus.src_l = {16'h0000, 16'h0000, 16'h0000, 16'hFC18};  // -1000 on ch0
    wait_frame(fc);
    check_eq("gain_l", bus.ldata, 16'hFF06);  // -250
    gain = '0;
`endif

    // Steady run with constant sources.
    bus.src_l = {4{16'hFFF9}};  // -7
    bus.src_r = {4{16'd5}};
    wait_frame(fc);
    last_fc = fc;
    stable_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_frame(fc);
      check_eq($sformatf("steady_spacing%0d", k), 32'(fc - last_fc), 32'(FR));
      check_eq($sformatf("steady_l%0d", k), bus.ldata, 16'hFFE4);
      last_fc = fc;
    end
    stable_en = 1'b0;
    check_eq("steady_stable", 32'(unstable), 32'd0);
    check_eq("steady_r", bus.rdata, 16'd20);

    // Reset while channel 1 is being polled.
    got1 = 1'b0;
    for (int n = 0; n < 4*FR && !got1; n++) begin
      step();
      if (bus.src_ready[1]) got1 = 1'b1;
    end
    check_eq("reach_ch1", got1, 1'b1);
    fr_before = frames;
    reset = 1'b0;
    step();
    check_reset_state("midrst");
    repeat (5) step();
    check_eq("midrst_noframe", 32'(frames - fr_before), 32'd0);
    reset = 1'b1;
    rel_cyc = cyc;
    clear_ready();
    wait_frame(fc);
    check_eq("midrst_delay", 32'(fc - rel_cyc), 32'(FR + CH + 1));
    check_eq("midrst_l", bus.ldata, 16'hFFE4);
    check_eq("midrst_ur", underrun, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
